// File: rtl/btc_programmer_pkg.sv
// -----------------------------------------------------------------------------
// btc_programmer_pkg
//
// Shared definitions for the configuration-bitchain programmer:
//   - state_t          : programmer FSM states
//   - clog2()          : ceiling log2, usable in constant expressions
//   - cnt_width()      : register width able to hold 0..n-1 (never below 1)
//   - chunks_per_word(): K, the number of chain chunks carried by one host word
//   - words_per_run()  : N_WORDS, the host words needed to fill the chain once
//
// K and N_WORDS depend on the parameters of each instance. The package
// therefore supplies the functions that compute them, and each module binds
// the results to its own localparams.
// -----------------------------------------------------------------------------
package btc_programmer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Ceiling log2: clog2(1) = 0, clog2(2) = 1, clog2(11) = 4.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Register width for a counter that spans 0..n-1. The result is at least 1.
  function automatic int cnt_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int chunks_per_word(input int host_width, input int chain_width);
    return host_width / chain_width;
  endfunction

  function automatic int words_per_run(input int chain_depth, input int k);
    return (chain_depth + k - 1) / k;
  endfunction

endpackage

// File: rtl/btc_rb_packer.sv
// -----------------------------------------------------------------------------
// btc_rb_packer
//
// Packs the chunks that leave the tail of the bitchain into host-width readback
// words. chunk_data goes into slot s, at bits [s*CHAIN_WIDTH +: CHAIN_WIDTH],
// with slot 0 filled first. A word is emitted when slot K-1 is written or when
// chunk_last marks the final chunk of a run. In a word cut short by
// chunk_last, the unused upper slots are zero. The emitted word is held stable
// on rb_data/rb_valid until the consumer takes it with rb_ready.
//
// The caller must not present a chunk while an emitted word is waiting
// (rb_valid && !rb_ready). The programmer already guarantees this through its
// shift enable, so the packer needs no backpressure output of its own.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   chunk_valid   a chunk is presented this cycle
//   chunk_data    chunk value (pre-shift chain tail)
//   chunk_last    this chunk is the last of the run; flush the partial word
//   rb_data       readback word (registered)
//   rb_valid      readback word valid (registered)
//   rb_ready      readback consumer ready
// -----------------------------------------------------------------------------
module btc_rb_packer
  import btc_programmer_pkg::*;
#(
  parameter int CHAIN_WIDTH = 1,
  parameter int HOST_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chunk_valid,
  input  logic [CHAIN_WIDTH-1:0] chunk_data,
  input  logic                   chunk_last,
  output logic [HOST_WIDTH-1:0]  rb_data,
  output logic                   rb_valid,
  input  logic                   rb_ready
);

  localparam int K      = chunks_per_word(HOST_WIDTH, CHAIN_WIDTH);
  localparam int SLOT_W = cnt_width(K);

  logic [HOST_WIDTH-1:0] acc;
  logic [HOST_WIDTH-1:0] acc_next;
  logic [SLOT_W-1:0]     slot;
  logic                  flush;

  // NOTE: every variable written in always_comb first gets a full default, so
  // each path assigns it and no latch is inferred.
  always_comb begin
    acc_next = acc;
    acc_next[int'(slot) * CHAIN_WIDTH +: CHAIN_WIDTH] = chunk_data;
  end

  assign flush = chunk_valid && ((slot == SLOT_W'(K - 1)) || chunk_last);

  // NOTE: the accumulator is datapath storage, but it is reset anyway. After a
  // run aborted by reset, the next readback word must start from zero padding
  // and not from stale chunks of the interrupted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      slot     <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked logic. A later assignment in
      // this block, such as the flush below, overrides this clear without any
      // ordering hazard between the statements.
      if (rb_valid && rb_ready) begin
        rb_valid <= 1'b0;
      end

      if (chunk_valid) begin
        if (flush) begin
          rb_data  <= acc_next;
          rb_valid <= 1'b1;
          acc      <= '0;
          slot     <= '0;
        end else begin
          acc  <= acc_next;
          slot <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/btc_programmer.sv
// -----------------------------------------------------------------------------
// btc_programmer
//
// Writer end of a configuration bitchain. After start, the block takes host
// words over a valid/ready stream. Each word is cut into CHAIN_WIDTH-bit
// chunks, LSB chunk first. The chain is driven with exactly CHAIN_DEPTH shifts,
// so the first chunk shifted ends up in the tail stage. The chunks pushed out of
// the tail during the run form the previous configuration. They are packed back
// into host words on the readback stream, so the host can verify them.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (aborts a run at once)
//   start        one-cycle run request; ignored unless idle
//   busy         high from the cycle after an accepted start through done
//   done         one-cycle pulse at the end of a run
//   host_data    configuration word from the host
//   host_valid   host word valid
//   host_ready   high only while waiting for the next word
//   cfg_i        chunk presented to the chain input (0 when not shifting)
//   cfg_e        chain shift enable; the chain shifts at the edge ending the cycle
//   cfg_o        chain tail output
//   rb_data      readback word
//   rb_valid     readback word valid
//   rb_ready     readback consumer ready
// -----------------------------------------------------------------------------
module btc_programmer
  import btc_programmer_pkg::*;
#(
  parameter int CHAIN_WIDTH = 1,
  parameter int CHAIN_DEPTH = 16,
  parameter int HOST_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [HOST_WIDTH-1:0]  host_data,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [CHAIN_WIDTH-1:0] cfg_i,
  output logic                   cfg_e,
  input  logic [CHAIN_WIDTH-1:0] cfg_o,
  output logic [HOST_WIDTH-1:0]  rb_data,
  output logic                   rb_valid,
  input  logic                   rb_ready
);

  localparam int K       = chunks_per_word(HOST_WIDTH, CHAIN_WIDTH);
  localparam int N_WORDS = words_per_run(CHAIN_DEPTH, K);
  localparam int CHUNK_W = cnt_width(K);
  localparam int SHIFT_W = cnt_width(CHAIN_DEPTH + 1);

  if (HOST_WIDTH % CHAIN_WIDTH != 0) begin : g_bad_host_width
    $error("btc_programmer: HOST_WIDTH must be an integer multiple of CHAIN_WIDTH");
  end

  if (N_WORDS < 1) begin : g_bad_depth
    $error("btc_programmer: CHAIN_DEPTH must be at least 1");
  end

  state_t                 state;
  logic [HOST_WIDTH-1:0]  word_buf;   // held word; consumed chunks shift out of the bottom
  logic [CHUNK_W-1:0]     chunk_cnt;  // chunk index within the held word, 0..K-1
  logic [SHIFT_W-1:0]     shift_cnt;  // shifts done this run, 0..CHAIN_DEPTH-1
  logic                   rb_stall;
  logic                   last_chunk;
  logic                   word_end;

  // A readback word that is still waiting freezes the chain. With no shift,
  // no tail chunk can be lost and the chain contents stay put.
  assign rb_stall   = rb_valid && !rb_ready;
  assign cfg_e      = (state == ST_SHIFT) && !rb_stall;
  assign cfg_i      = cfg_e ? word_buf[CHAIN_WIDTH-1:0] : '0;
  assign host_ready = (state == ST_LOAD);

  assign last_chunk = (shift_cnt == SHIFT_W'(CHAIN_DEPTH - 1));
  assign word_end   = (chunk_cnt == CHUNK_W'(K - 1));

  // Host words and readback words both hold K chunks. The packer's slot index
  // therefore matches chunk_cnt, and a new word load can overlap a readback
  // word that has not been taken yet.
  btc_rb_packer #(
    .CHAIN_WIDTH (CHAIN_WIDTH),
    .HOST_WIDTH  (HOST_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .chunk_valid (cfg_e),
    .chunk_data  (cfg_o),
    .chunk_last  (last_chunk),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid),
    .rb_ready    (rb_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word_buf  <= '0;
      chunk_cnt <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (host_valid) begin
            word_buf <= host_data;
            state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (cfg_e) begin
            word_buf <= word_buf >> CHAIN_WIDTH;
            if (last_chunk) begin
              // The upper chunks of a partially used final word are dropped here.
              state     <= ST_DRAIN;
              chunk_cnt <= '0;
              shift_cnt <= '0;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
              if (word_end) begin
                chunk_cnt <= '0;
                state     <= ST_LOAD;
              end else begin
                chunk_cnt <= chunk_cnt + 1'b1;
              end
            end
          end
        end

        ST_DRAIN: begin
          // The final chunk always flushes the packer, so the word seen here is
          // the last readback word of the run.
          if (rb_valid && rb_ready) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
